// File: rtl/hcsr04_pkg.sv
// Shared types and helpers for the HC-SR04 echo emulator.
package hcsr04_pkg;

  localparam int unsigned US_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StTrigHi,
    StDelay,
    StEcho,
    StHoldoff
  } state_e;

  function automatic int unsigned cycles_per_us(input int unsigned clk_freq_hz);
    return clk_freq_hz / 1_000_000;
  endfunction

endpackage

// File: rtl/us_timer.sv
// Microsecond interval timer: prescaler plus loadable down-counter.
// done pulses in the last cycle of a load_val*CPU cycle interval.
module us_timer
  import hcsr04_pkg::*;
#(
  parameter int unsigned CPU = 50
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [US_W-1:0] load_val,
  output logic            done
);

  localparam int unsigned PW = (CPU > 1) ? $clog2(CPU) : 1;
  localparam logic [PW-1:0] PreMax = PW'(CPU - 1);

  logic [PW-1:0]   pre_q, pre_d;
  logic [US_W-1:0] cnt_q, cnt_d;
  logic            tick;

  assign tick = (pre_q == PreMax);
  assign done = (cnt_q == US_W'(1)) && tick;

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (load) begin
      pre_d = '0;
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (tick) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 responder: validates a trigger pulse, waits the burst delay, then
// drives ECHO for a width proportional to the programmed distance.
module hcsr04_echo_emulator
  import hcsr04_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
  parameter int unsigned TRIG_MIN_US   = 10,
  parameter int unsigned ECHO_DELAY_US = 200,
  parameter int unsigned US_PER_CM     = 58,
  parameter int unsigned TIMEOUT_US    = 38000,
  parameter int unsigned HOLDOFF_US    = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trigg,
  input  logic [7:0] dist_cm,
  output logic       ECHO,
  output logic       busy,
  output logic       short_trig
);

  localparam int unsigned CPU     = cycles_per_us(CLK_FREQ_HZ);
  localparam int unsigned TrigMin = TRIG_MIN_US * CPU;
  localparam int unsigned TW      = $clog2(TrigMin + 1);
  localparam logic [TW-1:0] TrigMinC = TW'(TrigMin);

  logic            sync1_q, trig_s, trig_prev_q;
  state_e          state_q, state_d;
  logic [TW-1:0]   hi_q, hi_d;
  logic [7:0]      dist_q, dist_d;
  logic            short_d;
  logic            load, done;
  logic [US_W-1:0] load_val, echo_w;

  always_comb begin
    echo_w = (dist_q == '0) ? US_W'(TIMEOUT_US) : US_W'(dist_q) * US_W'(US_PER_CM);
  end

  // Timer is reloaded on entry to every timed state so intervals are cycle-exact.
  always_comb begin
    load = (state_d != state_q) && (state_d inside {StDelay, StEcho, StHoldoff});
    unique case (state_d)
      StDelay: load_val = US_W'(ECHO_DELAY_US);
      StEcho:  load_val = echo_w;
      default: load_val = US_W'(HOLDOFF_US);
    endcase
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    dist_d  = dist_q;
    short_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The edge cycle itself is the first high cycle of the trigger.
        if (trig_s && !trig_prev_q) begin
          state_d = StTrigHi;
          hi_d    = TW'(1);
        end
      end
      StTrigHi: begin
        if (trig_s) begin
          if (hi_q < TrigMinC) hi_d = hi_q + 1'b1;
        end else if (hi_q >= TrigMinC) begin
          dist_d  = dist_cm;
          state_d = StDelay;
        end else begin
          short_d = 1'b1;
          state_d = StIdle;
        end
      end
      StDelay:   if (done) state_d = StEcho;
      StEcho:    if (done) state_d = StHoldoff;
      StHoldoff: if (done) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      trig_s      <= 1'b0;
      trig_prev_q <= 1'b0;
      state_q     <= StIdle;
      hi_q        <= '0;
      dist_q      <= '0;
      ECHO        <= 1'b0;
      busy        <= 1'b0;
      short_trig  <= 1'b0;
    end else begin
      sync1_q     <= trigg;
      trig_s      <= sync1_q;
      trig_prev_q <= trig_s;
      state_q     <= state_d;
      hi_q        <= hi_d;
      dist_q      <= dist_d;
      ECHO        <= (state_q == StEcho);
      busy        <= (state_q != StIdle);
      short_trig  <= short_d;
    end
  end

  us_timer #(
    .CPU(CPU)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

endmodule
